// File: rtl/sd_pkg.sv
// Shared constants and types for the SD-over-SPI command sequencer.
// Frame constants and the CRC7 polynomial are kept here so they can be reused elsewhere.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SEND  = 3'd2,
        ST_POLL  = 3'd3,
        ST_TRAIL = 3'd4
    } sd_state_t;

    localparam logic [1:0] SD_START_BITS = 2'b01;
    localparam logic [7:0] SD_FILL       = 8'hFF;
    // x^7 + x^3 + 1, with the implicit x^7 term dropped
    localparam logic [6:0] SD_CRC7_POLY  = 7'h09;
    localparam int unsigned SD_ARG_BYTES = 4;

endpackage

// File: rtl/sd_crc7.sv
// Byte-wide CRC7 update, MSB first; purely combinational.
module sd_crc7
    import sd_pkg::*;
(
    input  logic [6:0] crc,
    input  logic [7:0] data,
    output logic [6:0] crc_next
);

    logic [6:0] stage [0:8];

    assign stage[0] = crc;

    // One shift/conditional-XOR stage per message bit, bit 7 first.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            logic fb;
            assign fb = stage[gi][6] ^ data[7 - gi];
            assign stage[gi + 1] = {stage[gi][5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
        end
    endgenerate

    assign crc_next = stage[8];

endmodule

// File: rtl/sd_cmd_seq.sv
// Sequences one SD SPI-mode command: fill byte, 6-byte frame, R1 polling, trailing fill byte.
// Drives a byte engine that exchanges one byte per spi_done pulse while spi_bv stays high.
module sd_cmd_seq
    import sd_pkg::*;
#(
    parameter int unsigned MAX_POLL = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        resp_valid,
    output logic [7:0]  resp,
    output logic        resp_timeout,
    output logic        cs_n,
    output logic        spi_bv,
    output logic [7:0]  spi_tx,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx
);

    localparam logic [7:0] POLL_LIMIT = 8'(MAX_POLL);

    sd_state_t   state_q, state_d;
    logic        cs_n_q, cs_n_d;
    logic        spi_bv_q, spi_bv_d;
    logic [7:0]  spi_tx_q, spi_tx_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [6:0]  crc_q, crc_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [7:0]  resp_q, resp_d;
    logic        resp_timeout_q, resp_timeout_d;
    logic        resp_valid_q, resp_valid_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;

    logic [7:0]  cmd_byte;
    logic [7:0]  arg_byte;
    logic [7:0]  crc_in;
    logic [6:0]  crc_next;
    logic [7:0]  poll_cnt_inc;

    assign cmd_byte     = {SD_START_BITS, cmd_index_q};
    assign poll_cnt_inc = poll_cnt_q + 8'd1;

    always_comb begin
        arg_byte = 8'h00;
        case (byte_idx_q)
            3'd0:    arg_byte = cmd_arg_q[31:24];
            3'd1:    arg_byte = cmd_arg_q[23:16];
            3'd2:    arg_byte = cmd_arg_q[15:8];
            3'd3:    arg_byte = cmd_arg_q[7:0];
            default: arg_byte = 8'h00;
        endcase
    end

    // The CRC is folded in on the same edge a frame byte is loaded, so the
    // unit only ever sees the command byte (SETUP) or an argument byte (SEND).
    assign crc_in = (state_q == ST_SETUP) ? cmd_byte : arg_byte;

    sd_crc7 u_crc7 (
        .crc      (crc_q),
        .data     (crc_in),
        .crc_next (crc_next)
    );

    always_comb begin
        state_d        = state_q;
        cs_n_d         = cs_n_q;
        spi_bv_d       = spi_bv_q;
        spi_tx_d       = spi_tx_q;
        byte_idx_d     = byte_idx_q;
        crc_d          = crc_q;
        poll_cnt_d     = poll_cnt_q;
        resp_d         = resp_q;
        resp_timeout_d = resp_timeout_q;
        resp_valid_d   = 1'b0;
        cmd_index_d    = cmd_index_q;
        cmd_arg_d      = cmd_arg_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cs_n_d      = 1'b0;
                    spi_bv_d    = 1'b1;
                    spi_tx_d    = SD_FILL;
                    byte_idx_d  = 3'd0;
                    crc_d       = 7'd0;
                    poll_cnt_d  = 8'd0;
                    cmd_index_d = cmd_index;
                    cmd_arg_d   = cmd_arg;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (spi_done) begin
                    spi_tx_d = cmd_byte;
                    crc_d    = crc_next;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (spi_done) begin
                    if (byte_idx_q < 3'(SD_ARG_BYTES)) begin
                        spi_tx_d   = arg_byte;
                        crc_d      = crc_next;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end else if (byte_idx_q == 3'(SD_ARG_BYTES)) begin
                        spi_tx_d   = {crc_q, 1'b1};
                        byte_idx_d = byte_idx_q + 3'd1;
                    end else begin
                        spi_tx_d   = SD_FILL;
                        poll_cnt_d = 8'd0;
                        state_d    = ST_POLL;
                    end
                end
            end
            ST_POLL: begin
                if (spi_done) begin
                    if (!spi_rx[7]) begin
                        resp_d         = spi_rx;
                        resp_timeout_d = 1'b0;
                        state_d        = ST_TRAIL;
                    end else begin
                        poll_cnt_d = poll_cnt_inc;
                        if (poll_cnt_inc == POLL_LIMIT) begin
                            resp_d         = SD_FILL;
                            resp_timeout_d = 1'b1;
                            state_d        = ST_TRAIL;
                        end
                    end
                end
            end
            ST_TRAIL: begin
                if (spi_done) begin
                    spi_bv_d     = 1'b0;
                    cs_n_d       = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cs_n_q         <= 1'b1;
            spi_bv_q       <= 1'b0;
            spi_tx_q       <= SD_FILL;
            byte_idx_q     <= 3'd0;
            crc_q          <= 7'd0;
            poll_cnt_q     <= 8'd0;
            resp_q         <= 8'h00;
            resp_timeout_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            cmd_index_q    <= 6'd0;
            cmd_arg_q      <= 32'd0;
        end else begin
            state_q        <= state_d;
            cs_n_q         <= cs_n_d;
            spi_bv_q       <= spi_bv_d;
            spi_tx_q       <= spi_tx_d;
            byte_idx_q     <= byte_idx_d;
            crc_q          <= crc_d;
            poll_cnt_q     <= poll_cnt_d;
            resp_q         <= resp_d;
            resp_timeout_q <= resp_timeout_d;
            resp_valid_q   <= resp_valid_d;
            cmd_index_q    <= cmd_index_d;
            cmd_arg_q      <= cmd_arg_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp         = resp_q;
    assign resp_timeout = resp_timeout_q;
    assign cs_n         = cs_n_q;
    assign spi_bv       = spi_bv_q;
    assign spi_tx       = spi_tx_q;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Randomised bench for sd_cmd_seq: a card model answers each byte after a random gap,
// and every transmitted byte and response is checked against a frame model built here.
module tb_sd_cmd_seq;

    localparam int MAX_POLL = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_valid;
    logic [7:0]  resp;
    logic        resp_timeout;
    logic        cs_n;
    logic        spi_bv;
    logic [7:0]  spi_tx;
    logic        spi_done;
    logic [7:0]  spi_rx;

    int n_vec = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int rv_cnt = 0;
    logic [7:0] last_resp = 8'h00;
    logic       last_to = 1'b0;

    sd_cmd_seq #(.MAX_POLL(MAX_POLL)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .resp_valid   (resp_valid),
        .resp         (resp),
        .resp_timeout (resp_timeout),
        .cs_n         (cs_n),
        .spi_bv       (spi_bv),
        .spi_tx       (spi_tx),
        .spi_done     (spi_done),
        .spi_rx       (spi_rx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && cmd_valid && cmd_ready) acc_cnt++;
        if (resp_valid) rv_cnt++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // CRC7 as the remainder of (message * x^7) divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_of(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    // resp_pos: 1-based poll byte on which the card answers; 0 or >MAX_POLL = never.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input int resp_pos, input logic [7:0] resp_byte,
                           input bit hold, input string name);
        logic [7:0] exp_q [$];
        logic [7:0] tx0, rx, exp_resp;
        logic [39:0] msg;
        int guard, n, gap, npoll, p;
        bit responded, done, exp_to;

        guard = 0;
        while (!cmd_ready && guard < 50) begin step(); guard++; end
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept_wait: cmd_ready=%b required 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_index = idx; cmd_arg = arg;
        step();
        if (!hold) cmd_valid = 1'b0;
        cmd_index = 6'($urandom); cmd_arg = $urandom;
        n_vec++;
        if ({cs_n, spi_bv, cmd_ready, spi_tx} !== {3'b010, 8'hFF}) begin
            n_err++;
            $display("FAIL %s accept_state: cs_n/bv/rdy/tx=%b%b%b/%h required 010/ff",
                     name, cs_n, spi_bv, cmd_ready, spi_tx);
        end

        msg = {2'b01, idx, arg};
        npoll = (resp_pos >= 1 && resp_pos <= MAX_POLL) ? resp_pos : MAX_POLL;
        exp_resp = (resp_pos >= 1 && resp_pos <= MAX_POLL) ? resp_byte : 8'hFF;
        exp_to = !(resp_pos >= 1 && resp_pos <= MAX_POLL);
        exp_q.push_back(8'hFF);
        for (int b = 4; b >= 0; b--) exp_q.push_back(msg[b*8 +: 8]);
        exp_q.push_back({crc7_of(msg), 1'b1});
        for (int b = 0; b < npoll + 1; b++) exp_q.push_back(8'hFF);

        n = 0; responded = 0; done = 0;
        while (!done && n < 40) begin
            gap = $urandom_range(0, 2);
            tx0 = spi_tx;
            for (int g = 0; g < gap; g++) begin
                step();
                n_vec++;
                if ({spi_bv, cs_n, spi_tx} !== {2'b10, tx0}) begin
                    n_err++;
                    $display("FAIL %s gap_hold byte %0d: bv/cs_n/tx=%b%b/%h required 10/%h",
                             name, n, spi_bv, cs_n, spi_tx, tx0);
                end
            end
            rx = 8'($urandom);
            if (n >= 7 && !responded) begin
                p = n - 6;
                if (p == resp_pos) begin rx = resp_byte; responded = 1; end
                else rx = rx | 8'h80;
            end
            n_vec++;
            if (n >= exp_q.size() || spi_tx !== exp_q[n]) begin
                n_err++;
                $display("FAIL %s tx_byte %0d: spi_tx=%h required %h", name, n, spi_tx,
                         (n < exp_q.size()) ? exp_q[n] : 8'hxx);
            end
            spi_done = 1'b1; spi_rx = rx;
            step();
            spi_done = 1'b0; spi_rx = 8'($urandom);
            n++;
            if (spi_bv !== 1'b1) done = 1;
        end

        n_vec++;
        if (n != exp_q.size()) begin
            n_err++;
            $display("FAIL %s byte_count: got %0d required %0d", name, n, exp_q.size());
        end
        n_vec++;
        if ({resp_valid, cs_n, resp, resp_timeout} !== {2'b11, exp_resp, exp_to}) begin
            n_err++;
            $display("FAIL %s result: rv/cs_n/resp/to=%b%b/%h/%b required 11/%h/%b",
                     name, resp_valid, cs_n, resp, resp_timeout, exp_resp, exp_to);
        end
        last_resp = exp_resp; last_to = exp_to;
        if (!hold) begin
            step();
            n_vec++;
            if ({resp_valid, resp, resp_timeout} !== {1'b0, exp_resp, exp_to}) begin
                n_err++;
                $display("FAIL %s pulse_hold: rv/resp/to=%b/%h/%b required 0/%h/%b",
                         name, resp_valid, resp, resp_timeout, exp_resp, exp_to);
            end
        end
        $display("cmd %s idx=%0d arg=%h bytes=%0d resp=%h to=%b", name, idx, arg, n, resp, resp_timeout);
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0;
        spi_done = 1'b0; spi_rx = 8'h00;
        step(); step();
        n_vec++;
        if ({cmd_ready, resp_valid, resp, resp_timeout, cs_n, spi_bv, spi_tx} !==
            {2'b10, 8'h00, 1'b0, 2'b10, 8'hFF}) begin
            n_err++;
            $display("FAIL reset_state: rdy/rv/resp/to/cs_n/bv/tx=%b%b/%h/%b/%b%b/%h required 10/00/0/10/ff",
                     cmd_ready, resp_valid, resp, resp_timeout, cs_n, spi_bv, spi_tx);
        end
        reset = 1'b0;
        step();
        last_resp = 8'h00; last_to = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_known_frames();
        run_cmd(6'd0, 32'h0000_0000, 1, 8'h01, 0, "cmd0");
        run_cmd(6'd8, 32'h0000_01AA, 3, 8'h01, 0, "cmd8");
        run_cmd(6'd55, 32'h0000_0000, 0, 8'h00, 0, "timeout");
        run_cmd(6'd17, 32'h1234_5678, MAX_POLL, 8'h05, 0, "last_poll");
        run_cmd(6'd41, 32'h4000_0000, MAX_POLL + 1, 8'h00, 0, "late_r1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run_cmd(6'($urandom), $urandom, int'($urandom_range(0, MAX_POLL + 2)),
                    8'($urandom) & 8'h7F, 0, "random");
    endtask

    task automatic test_reset_mid_send();
        cmd_valid = 1'b1; cmd_index = 6'd24; cmd_arg = 32'hDEAD_BEEF;
        step();
        cmd_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            spi_done = 1'b1; spi_rx = 8'($urandom);
            step();
            spi_done = 1'b0;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++;
        if ({cs_n, spi_bv, cmd_ready, resp_valid, spi_tx, resp} !== {4'b1010, 8'hFF, 8'h00}) begin
            n_err++;
            $display("FAIL mid_reset: cs_n/bv/rdy/rv/tx/resp=%b%b%b%b/%h/%h required 1010/ff/00",
                     cs_n, spi_bv, cmd_ready, resp_valid, spi_tx, resp);
        end
        $display("reset mid-send checked");
        run_cmd(6'd0, 32'h0000_0000, 1, 8'h01, 0, "post_reset_cmd0");
    endtask

    task automatic test_back_to_back();
        int acc0, rv0;
        acc0 = acc_cnt; rv0 = rv_cnt;
        for (int i = 0; i < 3; i++)
            run_cmd(6'($urandom), $urandom, int'($urandom_range(1, 4)), 8'($urandom) & 8'h7F,
                    1, "held_valid");
        cmd_valid = 1'b0;
        step();
        n_vec++;
        if ((acc_cnt - acc0) != 3 || (rv_cnt - rv0) != 3) begin
            n_err++;
            $display("FAIL back_to_back: accepts=%0d resp_valids=%0d required 3/3",
                     acc_cnt - acc0, rv_cnt - rv0);
        end
        $display("back-to-back accepts=%0d resp_valids=%0d", acc_cnt - acc0, rv_cnt - rv0);
    endtask

    task automatic test_idle_done();
        for (int i = 0; i < 5; i++) begin
            spi_done = 1'b1; spi_rx = 8'($urandom) & 8'h7F;
            step();
            spi_done = 1'b0;
            n_vec++;
            if ({cs_n, spi_bv, cmd_ready, resp_valid, spi_tx, resp, resp_timeout} !==
                {4'b1010, 8'hFF, last_resp, last_to}) begin
                n_err++;
                $display("FAIL idle_done %0d: cs_n/bv/rdy/rv/tx/resp/to=%b%b%b%b/%h/%h/%b required 1010/ff/%h/%b",
                         i, cs_n, spi_bv, cmd_ready, resp_valid, spi_tx, resp, resp_timeout,
                         last_resp, last_to);
            end
        end
        $display("idle spi_done pulses checked");
    endtask

    initial begin
        test_reset();
        test_known_frames();
        test_idle_done();
        test_random();
        test_reset_mid_send();
        test_back_to_back();
        test_idle_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sd_cmd_seq.md
SD_CMD_SEQ -- requirements
Module: sd_cmd_seq

Interface
REQ-001 SHALL have parameter MAX_POLL, 8, number of response-poll bytes before timeout (legal 1..255).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  high only in IDLE; accept = cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_index  input  6  SD command index, sampled on accept.
REQ-007 SHALL have port cmd_arg  input  32  SD argument, sampled on accept.
REQ-008 SHALL have port resp_valid  output  1  one-cycle pulse, sequence finished.
REQ-009 SHALL have port resp  output  8  R1 byte; held until next resp_valid.
REQ-010 SHALL have port resp_timeout  output  1  set with resp_valid if no R1 seen; held.
REQ-011 SHALL have port cs_n  output  1  card select, active low.
REQ-012 SHALL have port spi_bv  output  1  byte valid to SPI byte engine.
REQ-013 SHALL have port spi_tx  output  8  byte to transmit; stable while spi_bv high between spi_done pulses.
REQ-014 SHALL have port spi_done  input  1  one-cycle pulse, current byte exchanged.
REQ-015 SHALL have port spi_rx  input  8  received byte, valid only in the spi_done cycle.

Function
REQ-016 States SHALL be IDLE, SETUP, SEND, POLL, TRAIL; all outputs except cmd_ready registered.
REQ-017 On accept: cs_n<=0, spi_bv<=1, spi_tx<=8'hFF, byte index<=0, CRC<=0, state<=SETUP.
REQ-018 SETUP, spi_done: spi_tx<={2'b01,cmd_index}, state<=SEND.
REQ-019 SEND, spi_done: spi_tx advances through cmd_arg[31:24], [23:16], [15:8], [7:0], then {crc7,1'b1}; after the CRC byte completes, spi_tx<=8'hFF, poll count<=0, state<=POLL.
REQ-020 CRC7 (poly x^7+x^3+1, init 0, MSB first) SHALL fold in each of the 5 frame bytes in the same edge that byte is loaded to spi_tx.
REQ-021 spi_rx during SETUP and SEND SHALL be ignored.
REQ-022 POLL, spi_done with spi_rx[7]==0: resp<=spi_rx, resp_timeout<=0, state<=TRAIL, spi_tx stays 8'hFF.
REQ-023 POLL, spi_done with spi_rx[7]==1: poll count+1; if count reaches MAX_POLL, resp<=8'hFF, resp_timeout<=1, state<=TRAIL.
REQ-024 TRAIL, spi_done: spi_bv<=0, cs_n<=1, resp_valid<=1 for one cycle, state<=IDLE.
REQ-025 spi_bv SHALL stay high continuously from accept through the TRAIL spi_done edge; no gaps between bytes.
REQ-026 spi_done while in IDLE SHALL be ignored; cmd_valid while not IDLE SHALL be ignored and not latched.
REQ-027 A new command SHALL be accepted no earlier than the cycle after resp_valid (cmd_ready high in the resp_valid cycle is allowed; accept there is legal).
REQ-028 Poll counter SHALL be 8 bits and SHALL not wrap within one sequence.

Reset
REQ-029 reset SHALL override all other inputs in that cycle, including mid-sequence.
REQ-030 Reset values SHALL be: state IDLE, cmd_ready 1, resp_valid 0, resp 8'h00, resp_timeout 0, cs_n 1, spi_bv 0, spi_tx 8'hFF, CRC 0, counters 0.

Structure
REQ-031 The state encoding, SD_START_BITS 2'b01, SD_FILL 8'hFF and CRC7 polynomial SHALL live in shared package sd_pkg.
REQ-032 The CRC7 byte-wide update SHALL be sub-module sd_crc7 (inputs: crc[6:0], byte[7:0]; output: next crc[6:0]; combinational).

Verification
REQ-033 CMD0, arg 0, card returns 8'h01 on first poll -> spi_tx sequence FF,40,00,00,00,00,95,FF,FF; resp 8'h01; timeout 0.
REQ-034 CMD8, arg 32'h000001AA, R1 on third poll -> frame 48,00,00,01,AA,87; 3 poll bytes; resp 8'h01.
REQ-035 No R1, MAX_POLL=8 -> exactly 8 poll bytes plus 1 trail byte; resp 8'hFF; resp_timeout 1.
REQ-036 reset asserted mid-SEND -> next cycle cs_n 1, spi_bv 0, cmd_ready 1; subsequent CMD0 completes normally.
REQ-037 cmd_valid held high throughout a sequence -> exactly one accept per resp_valid; spi_done pulses in IDLE produce no output change.
